// File: rtl/clkdiv_pkg.sv
// Shared constants for the clock divider bank: counter width default,
// the minimum legal divisor and the stock divisors for a 100 MHz CLK_REF.
package clkdiv_pkg;

   localparam int CNT_W_DEF = 27;
   localparam int DIV_MIN   = 2;

   // Periods in CLK_REF cycles at 100 MHz
   localparam int DIV_2HZ   = 50_000_000;
   localparam int DIV_1HZ   = 100_000_000;
   localparam int DIV_FAST  = 4_000_000;
   localparam int DIV_BLINK = 80_000_000;

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: phase counter, active/pending divisor pair and the
// registered clock-level, tick and pending flags.  A new divisor is only
// adopted at a period boundary, while disabled, or on SYNC.
module clkdiv_chan
   import clkdiv_pkg::*;
#(
   parameter int               CNT_W   = CNT_W_DEF,
   parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_2HZ)
) (
   input  logic             CLK_REF,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sync,
   input  logic             we,
   input  logic [CNT_W-1:0] cfg_div,
   output logic             clk_out,
   output logic             tick,
   output logic             pend
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   // Divisors below the minimum would never toggle the output; saturate them.
   function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
      return (d < CNT_W'(DIV_MIN)) ? CNT_W'(DIV_MIN) : d;
   endfunction

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] div_act;
   logic [CNT_W-1:0] div_pend;
   logic [CNT_W-1:0] div_pend_nxt;
   logic [CNT_W-1:0] div_act_nxt;
   logic             wrap;
   logic             load;
   logic             clk_p1;
   logic             tick_p1;
   logic             pend_p1;

   // Period boundary detection; a same-cycle write is passed straight through
   // to div_act so it governs the period that starts next.
   always_comb begin
      wrap         = en && (cnt == div_act - ONE);
      load         = sync || !en || wrap;
      div_pend_nxt = we ? clamp_div(cfg_div) : div_pend;
      div_act_nxt  = load ? div_pend_nxt : div_act;
   end

   // Counter, divisor state and registered outputs (outputs reflect cnt of the previous cycle)
   always_ff @(posedge CLK_REF or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         div_act  <= clamp_div(DIV_RST);
         div_pend <= clamp_div(DIV_RST);
         clk_p1   <= 1'b0;
         tick_p1  <= 1'b0;
         pend_p1  <= 1'b0;
      end else begin
         cnt      <= load ? '0 : cnt + ONE;
         div_act  <= div_act_nxt;
         div_pend <= div_pend_nxt;
         clk_p1   <= en && (cnt < (div_act >> 1));
         tick_p1  <= wrap;
         pend_p1  <= (div_act_nxt != div_pend_nxt);
      end
   end

   assign clk_out = clk_p1;
   assign tick    = tick_p1;
   assign pend    = pend_p1;

endmodule

// File: rtl/clkdiv_bank.sv
// Bank of NUM_CH independent clock dividers sharing one configuration port
// and one SYNC phase-restart strobe.  The top holds only the CFG decode, the
// reset release synchroniser and the channel array.
module clkdiv_bank
   import clkdiv_pkg::*;
#(
   parameter int                      NUM_CH   = 4,
   parameter int                      CNT_W    = CNT_W_DEF,
   parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {CNT_W'(DIV_BLINK), CNT_W'(DIV_FAST),
                                                  CNT_W'(DIV_1HZ),   CNT_W'(DIV_2HZ)},
   localparam int                     CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              CLK_REF,
   input  logic              RST_N,
   input  logic [NUM_CH-1:0] EN,
   input  logic              SYNC,
   input  logic              CFG_WE,
   input  logic [CH_W-1:0]   CFG_CH,
   input  logic [CNT_W-1:0]  CFG_DIV,
   output logic [NUM_CH-1:0] CLK_OUT,
   output logic [NUM_CH-1:0] TICK,
   output logic [NUM_CH-1:0] PEND
);

   logic              rst_sync_n;
   logic [NUM_CH-1:0] we_ch;

   // Reset asserts asynchronously and releases on a clock edge, so channels
   // first count on the second CLK_REF edge after RST_N rises.
   always_ff @(posedge CLK_REF or negedge RST_N) begin
      if (!RST_N) rst_sync_n <= 1'b0;
      else        rst_sync_n <= 1'b1;
   end

   // Write strobe decode; channel numbers with no channel behind them match nothing.
   always_comb begin
      we_ch = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         we_ch[i] = CFG_WE && (int'(CFG_CH) == i);
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clkdiv_chan #(
         .CNT_W   (CNT_W),
         .DIV_RST (DIV_INIT[g*CNT_W +: CNT_W])
      ) u_chan (
         .CLK_REF (CLK_REF),
         .rst_n   (rst_sync_n),
         .en      (EN[g]),
         .sync    (SYNC),
         .we      (we_ch[g]),
         .cfg_div (CFG_DIV),
         .clk_out (CLK_OUT[g]),
         .tick    (TICK[g]),
         .pend    (PEND[g])
      );
   end

endmodule
